rf_envelope_avg: RTL and testbench

//  Downstream of the sample-delay stage: takes the delayed signed RF stream and produces a

---
 rtl/rf_envelope_avg_if.sv | 24 ++
 rtl/rf_envelope_avg.sv | 124 ++++++++++++
 tb/tb_rf_envelope_avg.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/rf_envelope_avg_if.sv
// Stream interface for the envelope averager: signed samples in, decimated
// unsigned envelope out through a valid/ready handshake plus a sticky overflow.
interface rf_envelope_avg_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  din_valid;
  logic [DATA_WIDTH-1:0] din;
  logic                  env_ready;
  logic                  env_valid;
  logic [DATA_WIDTH-1:0] env;
  logic                  overflow;

  // Producer of samples and consumer of results (the surrounding system).
  modport master (
    output din_valid, din, env_ready,
    input  env_valid, env, overflow
  );

  // The averager itself.
  modport slave (
    input  din_valid, din, env_ready,
    output env_valid, env, overflow
  );
endinterface

// File: rtl/rf_envelope_avg.sv
// Envelope estimator: saturating rectifier, boxcar average over 2^WIN_LOG2
// accepted samples, decimation by DECIM, and a one-entry output register with
// a sticky overflow flag when an unconsumed result is overwritten.
module rf_envelope_avg #(
  parameter int DATA_WIDTH = 16,
  parameter int WIN_LOG2   = 3,
  parameter int DECIM      = 4
) (
  input  logic             clk,
  input  logic             reset,
  rf_envelope_avg_if.slave bus
);

  localparam int WIN   = 1 << WIN_LOG2;
  localparam int SUM_W = DATA_WIDTH + WIN_LOG2 - 1;
  localparam int MAG_W = DATA_WIDTH - 1;
  localparam logic [7:0] CNT_LAST = 8'(DECIM - 1);

  // Stage 1: rectified sample
  logic [MAG_W-1:0]      abs_q, abs_d;
  logic                  s1_valid_q;
  logic [DATA_WIDTH-1:0] din_neg;

  // Stage 2: window, running sum, decimation
  logic [MAG_W-1:0]    win_q [WIN];
  logic [SUM_W-1:0]    sum_q, sum_d;
  logic [WIN_LOG2-1:0] wp_q;
  logic [7:0]          cnt_q;
  logic [MAG_W-1:0]    avg_q;
  logic                res_q, res_d;

  // Output register
  logic [DATA_WIDTH-1:0] env_q, env_d;
  logic                  env_valid_q, env_valid_d;
  logic                  overflow_q, overflow_d;

  // Rectify; the most negative input has no positive twin, so it saturates.
  always_comb begin
    din_neg = ~bus.din + 1'b1;
    if (bus.din == {1'b1, {MAG_W{1'b0}}}) begin
      abs_d = '1;
    end else if (bus.din[DATA_WIDTH-1]) begin
      abs_d = din_neg[MAG_W-1:0];
    end else begin
      abs_d = bus.din[MAG_W-1:0];
    end
  end

  // Stage-1 register: capture magnitude and a one-cycle valid flag.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      abs_q      <= '0;
      s1_valid_q <= 1'b0;
    end else begin
      s1_valid_q <= bus.din_valid;
      if (bus.din_valid) abs_q <= abs_d;
    end
  end

  // Next running sum: drop the oldest entry before adding the newest, so the
  // intermediate never exceeds the window total and cannot wrap.
  always_comb begin
    sum_d = sum_q - SUM_W'(win_q[wp_q]) + SUM_W'(abs_q);
    res_d = s1_valid_q && (cnt_q == CNT_LAST);
  end

  // Stage-2 registers: window buffer, sum, pointer, decimation counter.
  // NOTE: the window buffer is reset entry by entry because warm-up relies on
  // it starting at zero; it is small enough to live in flops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < WIN; i++) win_q[i] <= '0;
      sum_q <= '0;
      wp_q  <= '0;
      cnt_q <= '0;
      avg_q <= '0;
      res_q <= 1'b0;
    end else begin
      res_q <= res_d;
      if (s1_valid_q) begin
        win_q[wp_q] <= abs_q;
        sum_q       <= sum_d;
        wp_q        <= wp_q + 1'b1;
        avg_q       <= sum_d[SUM_W-1:WIN_LOG2];
        cnt_q       <= (cnt_q == CNT_LAST) ? 8'd0 : cnt_q + 8'd1;
      end
    end
  end

  // Output handshake: a new result always wins; losing an unconsumed one
  // latches the overflow flag.
  // NOTE: every variable gets its hold value first so no latch is inferred.
  always_comb begin
    env_d       = env_q;
    env_valid_d = env_valid_q;
    overflow_d  = overflow_q;
    if (env_valid_q && bus.env_ready) env_valid_d = 1'b0;
    if (res_q) begin
      env_d       = {1'b0, avg_q};
      env_valid_d = 1'b1;
      if (env_valid_q && !bus.env_ready) overflow_d = 1'b1;
    end
  end

  // Output register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      env_q       <= '0;
      env_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      env_q       <= env_d;
      env_valid_q <= env_valid_d;
      overflow_q  <= overflow_d;
    end
  end

  assign bus.env       = env_q;
  assign bus.env_valid = env_valid_q;
  assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_rf_envelope_avg.sv
// Directed bench for rf_envelope_avg with default parameters (16/3/4).
module tb_rf_envelope_avg;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  rf_envelope_avg_if #(.DATA_WIDTH(DW)) bus ();

  rf_envelope_avg #(.DATA_WIDTH(DW), .WIN_LOG2(3), .DECIM(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int last_cyc = 0;
  int res_q[$];
  int stamp_q[$];
  int s_cyc[8];

  always @(posedge clk) cyc <= cyc + 1;

  // Record every completed output transfer with the edge count it follows.
  always @(negedge clk) begin
    if (bus.env_valid && bus.env_ready) begin
      res_q.push_back(int'(bus.env));
      stamp_q.push_back(cyc);
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic send(input int v);
    bus.din       = DW'(v);
    bus.din_valid = 1'b1;
    @(posedge clk);
    #1;
    last_cyc      = cyc;
    bus.din_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset         = 1'b0;
    bus.din_valid = 1'b0;
    bus.din       = '0;
    idle(2);
    reset = 1'b1;
    res_q.delete();
    stamp_q.delete();
  endtask

  task automatic wait_results(input int n, input string tag);
    for (int i = 0; i < 20 && res_q.size() < n; i++) idle(1);
    if (res_q.size() < n) check(tag, res_q.size(), n);
  endtask

  initial begin
    reset         = 1'b0;
    bus.din_valid = 1'b0;
    bus.din       = '0;
    bus.env_ready = 1'b1;
    @(posedge clk);
    #1;

    // 1: outputs pinned while reset held, even with activity on the input.
    for (int i = 0; i < 6; i++) begin
      bus.din_valid = i[0];
      bus.din       = DW'(1000 * (i + 1));
      idle(1);
      if (i >= 3) begin
        check("rst_valid", int'(bus.env_valid), 0);
        check("rst_env", int'(bus.env), 0);
        check("rst_ovf", int'(bus.overflow), 0);
      end
    end
    do_reset();

    // 2: ramp with constant 100, two results, two-cycle latency.
    for (int i = 0; i < 8; i++) begin
      send(100);
      s_cyc[i] = last_cyc;
    end
    idle(5);
    check("ramp_count", res_q.size(), 2);
    wait_results(2, "ramp_timeout");
    check("ramp_r0", res_q[0], 50);
    check("ramp_r1", res_q[1], 100);
    check("ramp_lat0", stamp_q[0] - s_cyc[3], 2);
    check("ramp_lat1", stamp_q[1] - s_cyc[7], 2);

    // 3: saturation of the most negative code, then plain negative input.
    do_reset();
    for (int i = 0; i < 8; i++) send(-32768);
    wait_results(2, "sat_timeout");
    check("sat_r0", res_q[0], 16383);
    check("sat_r1", res_q[1], 32767);
    do_reset();
    for (int i = 0; i < 8; i++) send(-5);
    wait_results(2, "neg_timeout");
    check("neg_r0", res_q[0], 2);
    check("neg_r1", res_q[1], 5);

    // 4: window fills then drains; exercises pointer wrap and subtraction.
    do_reset();
    for (int i = 0; i < 8; i++) send(800);
    for (int i = 0; i < 8; i++) send(0);
    wait_results(4, "slide_timeout");
    check("slide_r0", res_q[0], 400);
    check("slide_r1", res_q[1], 800);
    check("slide_r2", res_q[2], 400);
    check("slide_r3", res_q[3], 0);

    // 4b: gaps between samples do not advance window or decimation.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      send(160);
      idle(2);
    end
    wait_results(1, "gap_timeout");
    check("gap_r0", res_q[0], 80);
    check("gap_count", res_q.size(), 1);

    // 5: backpressure with an overwrite, then release for one cycle.
    do_reset();
    bus.env_ready = 1'b0;
    for (int i = 0; i < 12; i++) send(80);
    idle(3);
    check("bp_valid", int'(bus.env_valid), 1);
    check("bp_ovf", int'(bus.overflow), 1);
    check("bp_env", int'(bus.env), 80);
    bus.env_ready = 1'b1;
    idle(1);
    bus.env_ready = 1'b0;
    check("bp_drain", int'(bus.env_valid), 0);
    check("bp_ovf_sticky", int'(bus.overflow), 1);
    check("bp_env_hold", int'(bus.env), 80);
    bus.env_ready = 1'b1;

    // 6: reset mid-stream discards everything in flight.
    do_reset();
    for (int i = 0; i < 6; i++) send(1000);
    reset = 1'b0;
    idle(1);
    check("mid_env", int'(bus.env), 0);
    check("mid_ovf", int'(bus.overflow), 0);
    reset = 1'b1;
    res_q.delete();
    stamp_q.delete();
    for (int i = 0; i < 4; i++) send(64);
    wait_results(1, "mid_timeout");
    check("mid_r0", res_q[0], 32);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
